// File: rtl/rf_pkg.sv
// rf_pkg: shared widths, register names and reset constants for the integer register file.
package rf_pkg;
    localparam int XLEN_DEFAULT = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NREGS_DEFAULT = 32;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN_DEFAULT-1:0] xlen_t;
    localparam reg_addr_t REG_ZERO = 5'd0;
    localparam reg_addr_t REG_SP = 5'd2;
    localparam xlen_t SP_RESET_DEFAULT = 32'h0110_0000;
endpackage

// File: rtl/rf_bypass_mux.sv
// rf_bypass_mux: write-first bypass for one read port, with x0 forced to zero.
module rf_bypass_mux
    import rf_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] array_value,
    input  reg_addr_t       read_addr,
    input  reg_addr_t       write_addr,
    input  logic [XLEN-1:0] write_data,
    input  logic            write_enable,
    output logic [XLEN-1:0] value
);
    always_comb begin
        value = (read_addr == REG_ZERO) ? '0 :
                (write_enable && write_addr == read_addr) ? write_data : array_value;
    end
endmodule

// File: rtl/register_file.sv
// register_file: 32x32 integer registers, 2 registered read ports, 1 write port, write-first bypass; REGFILE_WRITE_COUNT_EN adds write_count.
module register_file
    import rf_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter int              NREGS    = NREGS_DEFAULT,
    parameter logic [XLEN-1:0] SP_RESET = SP_RESET_DEFAULT
) (
    input  logic            clock,
    input  logic            reset,
    input  reg_addr_t       addr_rs1,
    input  reg_addr_t       addr_rs2,
    input  logic            read_enable,
    input  reg_addr_t       addr_rd,
    input  logic [XLEN-1:0] data_rd,
    input  logic            write_enable,
    output logic [XLEN-1:0] data_rs1,
    output logic [XLEN-1:0] data_rs2
`ifdef REGFILE_WRITE_COUNT_EN
    ,
    output logic [31:0]     write_count
`endif
);
    logic [XLEN-1:0] regs [NREGS];
    logic [XLEN-1:0] value_rs1, value_rs2;
    logic            commit;

    assign commit = write_enable && addr_rd != REG_ZERO;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= (i == int'(REG_SP)) ? SP_RESET : '0;
        end else if (commit) begin
            regs[addr_rd] <= data_rd;
        end
    end

    rf_bypass_mux #(.XLEN(XLEN)) u_bypass_rs1 (
        .array_value (regs[addr_rs1]),
        .read_addr   (addr_rs1),
        .write_addr  (addr_rd),
        .write_data  (data_rd),
        .write_enable(write_enable),
        .value       (value_rs1)
    );

    rf_bypass_mux #(.XLEN(XLEN)) u_bypass_rs2 (
        .array_value (regs[addr_rs2]),
        .read_addr   (addr_rs2),
        .write_addr  (addr_rd),
        .write_data  (data_rd),
        .write_enable(write_enable),
        .value       (value_rs2)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            data_rs1 <= '0;
            data_rs2 <= '0;
        end else if (read_enable) begin
            data_rs1 <= value_rs1;
            data_rs2 <= value_rs2;
        end
    end

`ifdef REGFILE_WRITE_COUNT_EN
    always_ff @(posedge clock) begin
        if (reset) write_count <= '0;
        else if (commit) write_count <= write_count + 32'd1;
    end
`endif
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed and randomized checks of register_file against an array model.
module tb_register_file;
    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  addr_rs1, addr_rs2, addr_rd;
    logic        read_enable, write_enable;
    logic [31:0] data_rd, data_rs1, data_rs2;
`ifdef REGFILE_WRITE_COUNT_EN
    logic [31:0] write_count;
`endif

    int checks = 0;
    int failures = 0;
    logic [31:0] model [32];
    logic [31:0] exp_rs1, exp_rs2, exp_wc;

    register_file dut (
        .clock       (clock),
        .reset       (reset),
        .addr_rs1    (addr_rs1),
        .addr_rs2    (addr_rs2),
        .read_enable (read_enable),
        .addr_rd     (addr_rd),
        .data_rd     (data_rd),
        .write_enable(write_enable),
        .data_rs1    (data_rs1),
        .data_rs2    (data_rs2)
`ifdef REGFILE_WRITE_COUNT_EN
        ,
        .write_count (write_count)
`endif
    );

    always #5 clock = ~clock;

    // Model: apply the write first, then read the updated array, which is write-first by construction.
    task automatic tick();
        if (reset) begin
            foreach (model[i]) model[i] = 32'd0;
            model[2] = 32'h0110_0000;
            exp_rs1 = 32'd0;
            exp_rs2 = 32'd0;
            exp_wc = 32'd0;
        end else begin
            if (write_enable && addr_rd != 5'd0) begin
                model[addr_rd] = data_rd;
                exp_wc = exp_wc + 32'd1;
            end
            if (read_enable) begin
                exp_rs1 = model[addr_rs1];
                exp_rs2 = model[addr_rs2];
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2, input logic re,
                         input logic we, input logic [4:0] rd, input logic [31:0] d);
        reset = rst; addr_rs1 = rs1; addr_rs2 = rs2; read_enable = re;
        write_enable = we; addr_rd = rd; data_rd = d;
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 1, 0, 0, 0);
        tick();
        checks++;
        if (data_rs1 !== 32'd0 || data_rs2 !== 32'd0) begin
            failures++;
            $display("FAIL reset_out rs1=%h rs2=%h want 0 0", data_rs1, data_rs2);
        end
        drive(0, 0, 2, 1, 0, 0, 0);
        tick();
        checks++;
        if (data_rs1 !== 32'd0 || data_rs2 !== 32'h0110_0000) begin
            failures++;
            $display("FAIL reset_x0_x2 rs1=%h rs2=%h want 0 01100000", data_rs1, data_rs2);
        end
        drive(0, 5, 2, 1, 0, 0, 0);
        tick();
        checks++;
        if (data_rs1 !== 32'd0) begin
            failures++;
            $display("FAIL reset_x5 rs1=%h want 0", data_rs1);
        end
    endtask

    task automatic test_write_read();
        drive(0, 0, 0, 1, 1, 5, 32'hDEADBEEF);
        tick();
        drive(0, 5, 0, 1, 0, 0, 0);
        tick();
        checks++;
        if (data_rs1 !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL write_read rs1=%h want deadbeef", data_rs1);
        end
    endtask

    task automatic test_bypass();
        drive(0, 7, 7, 1, 1, 7, 32'h1234_5678);
        tick();
        checks++;
        if (data_rs1 !== 32'h1234_5678 || data_rs2 !== 32'h1234_5678) begin
            failures++;
            $display("FAIL bypass rs1=%h rs2=%h want 12345678", data_rs1, data_rs2);
        end
    endtask

    task automatic test_x0();
        logic [31:0] wc_before;
        wc_before = exp_wc;
        drive(0, 0, 5, 1, 1, 0, 32'hFFFF_FFFF);
        tick();
        checks++;
        if (data_rs1 !== 32'd0) begin
            failures++;
            $display("FAIL x0_same rs1=%h want 0", data_rs1);
        end
        drive(0, 0, 5, 1, 0, 0, 0);
        tick();
        checks++;
        if (data_rs1 !== 32'd0 || data_rs2 !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL x0_next rs1=%h rs2=%h want 0 deadbeef", data_rs1, data_rs2);
        end
`ifdef REGFILE_WRITE_COUNT_EN
        checks++;
        if (write_count !== wc_before) begin
            failures++;
            $display("FAIL x0_count got=%0d want=%0d", write_count, wc_before);
        end
`endif
    endtask

    task automatic test_stall();
        drive(0, 3, 0, 1, 1, 3, 32'h0000_0011);
        tick();
        checks++;
        if (data_rs1 !== 32'h0000_0011) begin
            failures++;
            $display("FAIL stall_pre rs1=%h want 11", data_rs1);
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 3, 3, 0, 1, 3, 32'hA5A5_A5A5);
            tick();
            checks++;
            if (data_rs1 !== 32'h0000_0011) begin
                failures++;
                $display("FAIL stall_hold%0d rs1=%h want 11", i, data_rs1);
            end
        end
        drive(0, 3, 0, 1, 0, 0, 0);
        tick();
        checks++;
        if (data_rs1 !== 32'hA5A5_A5A5) begin
            failures++;
            $display("FAIL stall_release rs1=%h want a5a5a5a5", data_rs1);
        end
    endtask

    task automatic test_reset_priority();
        drive(1, 9, 9, 1, 1, 9, 32'h5555_5555);
        tick();
        checks++;
        if (data_rs1 !== 32'd0 || data_rs2 !== 32'd0) begin
            failures++;
            $display("FAIL rstpri_out rs1=%h rs2=%h want 0 0", data_rs1, data_rs2);
        end
        drive(0, 9, 2, 1, 0, 0, 0);
        tick();
        checks++;
        if (data_rs1 !== 32'd0 || data_rs2 !== 32'h0110_0000) begin
            failures++;
            $display("FAIL rstpri_regs rs1=%h rs2=%h want 0 01100000", data_rs1, data_rs2);
        end
`ifdef REGFILE_WRITE_COUNT_EN
        checks++;
        if (write_count !== 32'd0) begin
            failures++;
            $display("FAIL rstpri_count got=%0d want=0", write_count);
        end
`endif
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 59) == 0, 5'($urandom), 5'($urandom), $urandom_range(0, 4) != 0,
                  $urandom_range(0, 2) != 0, ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom),
                  $urandom);
            if ($urandom_range(0, 3) == 0) addr_rs1 = addr_rd;
            if ($urandom_range(0, 3) == 0) addr_rs2 = addr_rd;
            tick();
            checks++;
            if (data_rs1 !== exp_rs1 || data_rs2 !== exp_rs2) begin
                failures++;
                $display("FAIL random%0d rs1=%h rs2=%h want %h %h", n, data_rs1, data_rs2, exp_rs1, exp_rs2);
            end
`ifdef REGFILE_WRITE_COUNT_EN
            checks++;
            if (write_count !== exp_wc) begin
                failures++;
                $display("FAIL random_count%0d got=%0d want=%0d", n, write_count, exp_wc);
            end
`endif
        end
    endtask

    initial begin
        exp_rs1 = 0; exp_rs2 = 0; exp_wc = 0;
        foreach (model[i]) model[i] = 32'd0;
        drive(1, 0, 0, 0, 0, 0, 0);
        #1;
        test_reset();
        test_write_read();
        test_bypass();
        test_x0();
        test_stall();
        test_reset_priority();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- Integer register file consuming the decoder's rs1/rs2/rd fields; sits directly downstream of decode in the pd pipeline.
- 32 x 32-bit architectural registers, two synchronous read ports, one write port.
- Write-first bypass, so a same-cycle writeback is visible to decode-stage reads.
- Read outputs are registered and feed the execute stage one cycle after addresses are presented.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers (address width = clog2(NREGS) = 5).
- SP_RESET, 32'h0110_0000, reset value of x2 (stack pointer): imemory base 32'h0100_0000 plus 1 MiB.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- addr_rs1  input  5  read port 1 address (decoder rs1).
- addr_rs2  input  5  read port 2 address (decoder rs2).
- read_enable  input  1  1 = capture new read data; 0 = hold data_rs1/data_rs2 (stall).
- addr_rd  input  5  write address (writeback rd).
- data_rd  input  XLEN  write data.
- write_enable  input  1  commit data_rd to addr_rd on this edge.
- data_rs1  output  XLEN  registered read data, port 1.
- data_rs2  output  XLEN  registered read data, port 2.

Behaviour:
- Reset (sync, active-high, sampled on posedge clock):
  - All registers cleared to 0, except x2 = SP_RESET.
  - data_rs1 = data_rs2 = 0.
  - Reset has priority over a simultaneous write and read; both are dropped.
- Write: on posedge, if !reset && write_enable && addr_rd != 0, then regs[addr_rd] <= data_rd.
- x0: writes to x0 are ignored; x0 always reads 0, including via bypass.
- Read: on posedge, if !reset && read_enable, then data_rsN <= value(addr_rsN).
  - Latency: exactly 1 cycle from address to output.
- Write-first bypass: value(a) = data_rd if write_enable && addr_rd == a && a != 0; otherwise regs[a].
  - Same-edge write and read of one register returns the new value.
- Both ports may read the same register; each bypasses independently.
- read_enable = 0: outputs hold their previous values. A write landing during the stall is visible once read_enable returns to 1.
- No X propagation: every address 0..31 is valid; no out-of-range case exists.

Optional Feature:
- Macro: REGFILE_WRITE_COUNT_EN.
- Defined:
  - Adds output port write_count [31:0].
  - Increments by 1 on each committed write: write_enable && addr_rd != 0 && !reset.
  - Writes to x0 do not count.
  - Reset to 0; wraps from 32'hFFFF_FFFF to 0.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package rf_pkg:
  - XLEN_DEFAULT = 32, REG_ADDR_W = 5, NREGS_DEFAULT = 32.
  - REG_ZERO = 5'd0, REG_SP = 5'd2, SP_RESET_DEFAULT = 32'h0110_0000.
  - Typedefs reg_addr_t (5-bit) and xlen_t (32-bit).
- One sub-module: rf_bypass_mux, purely combinational, one instance per read port.
  - Inputs: array read value, read address, write address/data/enable.
  - Output: bypassed value, including the x0 force-to-zero.

Test Plan:
- Reset 1 cycle, then read x0, x2, x5 -> next cycle outputs 0, 32'h0110_0000, 0.
- Write x5 = 32'hDEADBEEF, then read rs1 = x5 next cycle -> data_rs1 = 32'hDEADBEEF one cycle after the read.
- Same edge: write x7 = 32'h1234_5678, read rs1 = rs2 = x7 -> both outputs = 32'h1234_5678 (bypass).
- Write x0 = 32'hFFFF_FFFF with rs1 = x0 on the same and the following cycle -> data_rs1 = 0 both times.
  - With REGFILE_WRITE_COUNT_EN defined, write_count does not increment.
- read_enable = 0 for 3 cycles while writing x3 = 32'hA5A5_A5A5, rs1 = x3 -> data_rs1 holds the old value.
  - After read_enable returns to 1 -> 32'hA5A5_A5A5.
- Assert reset together with write_enable (x9 = 32'h5555_5555) -> x9 reads 0 afterwards and x2 = 32'h0110_0000.
  - With REGFILE_WRITE_COUNT_EN defined, write_count = 0.
